id_issue_queue: RTL and testbench
=================================

# id_issue_queue

Parametrised decode-to-issue buffer. It replaces the single-entry ID/issue pipeline register with a DEPTH-entry in-order FIFO that accepts up to NR_IN decoded instructions per cycle and presents one instruction per cycle to the issue stage. Each entry carries an opaque decoded payload plus a control-flow flag. The block sits between the decoder lanes and the issue stage, and honours the controller flush.

## Interface
- DATA_WIDTH, 64: width of the opaque payload (scoreboard entry plus original instruction, packed by the instantiating stage).
- DEPTH, 4: number of entries. Must be a power of 2, ≥2 and ≥NR_IN.
- NR_IN, 2: number of input lanes, 1 or 2.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  controller flush; empties the queue.
- in_valid_i  in  NR_IN  per-lane valid. Valid lanes are contiguous from lane 0.
- in_data_i  in  NR_IN×DATA_WIDTH  per-lane payload.
- in_ctrl_flow_i  in  NR_IN  per-lane control-flow flag.
- in_ready_o  out  NR_IN  per-lane ready.
- out_valid_o  out  1  head entry valid.
- out_data_o  out  DATA_WIDTH  head payload.
- out_ctrl_flow_o  out  1  head control-flow flag.
- out_ack_i  in  1  issue stage consumes the head entry.
- count_o  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- Storage:
  - DEPTH-entry circular buffer.
  - Read pointer and write pointer are $clog2(DEPTH) bits wide and wrap naturally.
  - The occupancy counter is kept separately.
- Dequeue:
  - deq = out_ack_i & out_valid_o.
  - out_ack_i with out_valid_o=0 is ignored.
- Free slots: free = DEPTH − count + deq.
- Ready: in_ready_o[k] = (free > k). This is a combinational path from out_ack_i to in_ready_o, by design.
- Lane acceptance:
  - acc[0] = in_valid_i[0] & in_ready_o[0].
  - acc[k] = acc[k−1] & in_valid_i[k] & in_ready_o[k].
  - A lane with a valid but no valid on a lower lane is ignored. Bench asserts this never happens.
- Enqueue:
  - Accepted lanes are written in lane order at wptr, wptr+1, … modulo DEPTH.
  - wptr advances by popcount(acc).
- Head:
  - out_valid_o = (count ≠ 0).
  - out_data_o and out_ctrl_flow_o are driven from the entry at rptr.
  - rptr advances by 1 on deq.
- count_next = count + popcount(acc) − deq. Simultaneous enqueue and dequeue on a full queue is legal, because free counts the dequeue.
- Flush:
  - flush_i has priority over everything.
  - Next cycle: count=0, rptr=wptr=0.
  - Lanes accepted in the flush cycle are discarded. in_ready_o still follows the normal rule, so the frontend drains.
  - A dequeue in the flush cycle is honoured on the interface (the consumer sees the handshake) but has no further effect.
- Payload storage is not reset; only pointers and count are reset.

## Timing
- Reset values:
  - count_o=0, out_valid_o=0.
  - in_ready_o all 1.
  - out_data_o and out_ctrl_flow_o are X-tolerant; the bench must not check them while out_valid_o=0.
- Latency:
  - Enqueue into an empty queue gives out_valid_o=1 on the next cycle.
  - There is no same-cycle bypass.
- Throughput:
  - One dequeue per cycle, sustained.
  - NR_IN enqueues per cycle while free ≥ NR_IN.
- Full (count=DEPTH, no deq): in_ready_o=0 on all lanes.
- Full with deq: in_ready_o[0]=1 and lane ≥1 ready=0 in the same cycle.
- Reset mid-operation: state returns to reset values immediately (asynchronous) and no entry survives.
- Pointer wrap: entries are delivered strictly in FIFO order across the DEPTH boundary.

## Test plan
All scenarios use DEPTH=4, NR_IN=2, DATA_WIDTH=8.
- Reset, then lane0 valid with data 0x11 and ctrl-flow 1, ack held 0 → next cycle out_valid_o=1, out_data_o=0x11, out_ctrl_flow_o=1, count_o=1. Held stable until acked.
- Dual-lane fill, ack held 0: cycle 0 writes 0xA0 and 0xA1, cycle 1 writes 0xA2 and 0xA3 → count_o=4, in_ready_o=2'b00. A third attempt is not accepted. Then ack for 4 cycles → outputs 0xA0, 0xA1, 0xA2, 0xA3 in order, then out_valid_o=0.
- Full queue, ack=1, both lanes valid with 0xB0 and 0xB1 → in_ready_o=2'b01. Only 0xB0 is written, count_o stays 4, and 0xB0 appears after the three remaining old entries.
- Wrap: 10 cycles of single-lane enqueue of values 0..9 with concurrent ack once data is present → output sequence 0..9, count_o never exceeds 1.
- Flush with count=3 and lanes valid (0xC0, 0xC1) in the same cycle → next cycle count_o=0, out_valid_o=0. The following enqueue of 0xD0 is output as the first entry.
- Assert rst_ni low while count_o=2 → out_valid_o=0, count_o=0 and in_ready_o=2'b11 immediately, before the next clock edge.

Source files
------------

// File: rtl/id_issue_queue.sv
// id_issue_queue: in-order FIFO between the decoder lanes and the issue stage.
// Accepts up to NR_IN decoded instructions per cycle and hands one per cycle
// to issue. Only pointers and occupancy are reset; payload storage is not.
module id_issue_queue #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned NR_IN      = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic [NR_IN-1:0]                    in_valid_i,
  input  logic [NR_IN-1:0][DATA_WIDTH-1:0]    in_data_i,
  input  logic [NR_IN-1:0]                    in_ctrl_flow_i,
  output logic [NR_IN-1:0]                    in_ready_o,
  output logic                                out_valid_o,
  output logic [DATA_WIDTH-1:0]               out_data_o,
  output logic                                out_ctrl_flow_o,
  input  logic                                out_ack_i,
  output logic [$clog2(DEPTH+1)-1:0]          count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic                  cf;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q;
  logic   [PW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
  logic   [CW-1:0]    cnt_q, cnt_d;
  logic               deq;
  logic   [CW:0]      free;
  logic   [NR_IN-1:0] acc;
  logic   [CW-1:0]    npush;

  assign out_valid_o     = (cnt_q != '0);
  assign deq             = out_ack_i & out_valid_o;
  assign count_o         = cnt_q;
  assign out_data_o      = mem_q[rptr_q].data;
  assign out_ctrl_flow_o = mem_q[rptr_q].cf;

  // Free slots count the same-cycle dequeue, so a full queue being drained
  // can still take one new entry (combinational ack -> ready path).
  assign free = (CW+1)'(DEPTH) - (CW+1)'(cnt_q) + (CW+1)'(deq);

  // Per-lane ready and in-order acceptance chain: a lane is taken only if
  // every lower lane was taken too.
  for (genvar k = 0; k < NR_IN; k++) begin : g_lane
    assign in_ready_o[k] = (free > (CW+1)'(k));
    if (k == 0) begin : g_first
      assign acc[k] = in_valid_i[k] & in_ready_o[k];
    end else begin : g_rest
      assign acc[k] = acc[k-1] & in_valid_i[k] & in_ready_o[k];
    end
  end

  // Number of lanes accepted this cycle.
  always_comb begin
    npush = '0;
    for (int k = 0; k < NR_IN; k++) npush = npush + CW'(acc[k]);
  end

  // Pointer/occupancy next state; flush wins over enqueue and dequeue.
  always_comb begin
    rptr_d = rptr_q + PW'(deq);
    wptr_d = wptr_q + PW'(npush);
    cnt_d  = cnt_q + npush - CW'(deq);
    if (flush_i) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload write: accepted lanes land at consecutive slots from wptr.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NR_IN; k++) begin
      if (acc[k] && !flush_i) begin
        mem_q[wptr_q + PW'(k)] <= '{cf: in_ctrl_flow_i[k], data: in_data_i[k]};
      end
    end
  end

endmodule

// File: tb/tb_id_issue_queue.sv
// Bench for id_issue_queue (DEPTH=4, NR_IN=2, DATA_WIDTH=8). A queue holds
// the entries the bench expects at the head, pushed when lanes are accepted.
module tb_id_issue_queue;
  localparam int DW = 8;
  localparam int D  = 4;
  localparam int N  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                flush = 1'b0;
  logic                ack = 1'b0;
  logic [N-1:0]        vld = '0;
  logic [N-1:0]        cfin = '0;
  logic [N-1:0][DW-1:0] din = '0;
  logic [N-1:0]        rdy;
  logic                ov;
  logic [DW-1:0]       od;
  logic                ocf;
  logic [2:0]          cnt;

  typedef struct packed {
    logic          cf;
    logic [DW-1:0] d;
  } ent_t;

  ent_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   peak;

  id_issue_queue #(.DATA_WIDTH(DW), .DEPTH(D), .NR_IN(N)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(vld), .in_data_i(din), .in_ctrl_flow_i(cfin), .in_ready_o(rdy),
    .out_valid_o(ov), .out_data_o(od), .out_ctrl_flow_o(ocf),
    .out_ack_i(ack), .count_o(cnt)
  );

  always #5 clk = ~clk;

  // Valid lanes must be contiguous from lane 0.
  always @(posedge clk) if (rst_n) assert (!(vld[1] && !vld[0]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // One cycle: inputs already driven; check at negedge, update model at posedge.
  task automatic cyc();
    int fr;
    bit dq;
    logic [1:0] er;
    @(negedge clk);
    dq = ack && (sb.size() != 0);
    fr = D - sb.size() + int'(dq);
    er = {fr > 1, fr > 0};
    chk("ready", 32'(rdy), 32'(er));
    chk("valid", 32'(ov), 32'(sb.size() != 0));
    chk("count", 32'(cnt), 32'(sb.size()));
    if (sb.size() != 0) begin
      chk("data", 32'(od), 32'(sb[0].d));
      chk("cflow", 32'(ocf), 32'(sb[0].cf));
    end
    if (int'(cnt) > peak) peak = int'(cnt);
    @(posedge clk);
    if (flush) sb.delete();
    else begin
      if (dq) void'(sb.pop_front());
      if (vld[0] && er[0]) begin
        sb.push_back('{cf: cfin[0], d: din[0]});
        if (vld[1] && er[1]) sb.push_back('{cf: cfin[1], d: din[1]});
      end
    end
    #1;
  endtask

  task automatic drv(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                     input logic [1:0] c, input logic a, input logic f);
    vld = v; din[0] = d0; din[1] = d1; cfin = c; ack = a; flush = f;
    cyc();
  endtask

  task automatic idle(input logic a);
    drv(2'b00, 8'h00, 8'h00, 2'b00, a, 1'b0);
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_count", 32'(cnt), 0);
    chk("rst_valid", 32'(ov), 0);
    chk("rst_ready", 32'(rdy), 32'h3);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single entry, held until acked
    drv(2'b01, 8'h11, 8'h00, 2'b01, 1'b0, 1'b0);
    chk("t1_data", 32'(od), 32'h11);
    chk("t1_cf", 32'(ocf), 1);
    chk("t1_count", 32'(cnt), 1);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Dual-lane fill, third attempt refused, then drain in order
    drv(2'b11, 8'hA0, 8'hA1, 2'b10, 1'b0, 1'b0);
    drv(2'b11, 8'hA2, 8'hA3, 2'b01, 1'b0, 1'b0);
    chk("t2_count", 32'(cnt), 4);
    chk("t2_ready", 32'(rdy), 0);
    drv(2'b11, 8'hEE, 8'hEF, 2'b00, 1'b0, 1'b0);
    chk("t2_count_hold", 32'(cnt), 4);
    repeat (4) idle(1'b1);
    chk("t2_empty", 32'(ov), 0);

    // Full queue with ack: only lane 0 enters
    drv(2'b11, 8'h30, 8'h31, 2'b00, 1'b0, 1'b0);
    drv(2'b11, 8'h32, 8'h33, 2'b00, 1'b0, 1'b0);
    vld = 2'b11; din[0] = 8'hB0; din[1] = 8'hB1; cfin = 2'b11; ack = 1'b1;
    #1;
    chk("t3_ready", 32'(rdy), 32'h1);
    cyc();
    chk("t3_count", 32'(cnt), 4);
    repeat (4) idle(1'b1);

    // Pointer wrap with concurrent ack
    peak = 0;
    for (int i = 0; i < 10; i++) drv(2'b01, 8'(i), 8'h00, {1'b0, 1'(i)}, 1'b1, 1'b0);
    idle(1'b1);
    chk("wrap_peak", 32'(peak), 1);

    // Flush with lanes valid in the same cycle
    drv(2'b11, 8'h50, 8'h51, 2'b00, 1'b0, 1'b0);
    drv(2'b01, 8'h52, 8'h00, 2'b00, 1'b0, 1'b0);
    drv(2'b11, 8'hC0, 8'hC1, 2'b00, 1'b0, 1'b1);
    chk("fl_count", 32'(cnt), 0);
    chk("fl_valid", 32'(ov), 0);
    drv(2'b01, 8'hD0, 8'h00, 2'b00, 1'b0, 1'b0);
    chk("fl_first", 32'(od), 32'hD0);
    idle(1'b1);

    // Asynchronous reset mid-operation
    drv(2'b11, 8'h60, 8'h61, 2'b00, 1'b0, 1'b0);
    idle(1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ov), 0);
    chk("arst_count", 32'(cnt), 0);
    chk("arst_ready", 32'(rdy), 32'h3);
    sb.delete();
    vld = '0; ack = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    idle(1'b0);
    drv(2'b01, 8'h77, 8'h00, 2'b01, 1'b0, 1'b0);
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      int v;
      v = $urandom_range(0, 2);
      drv((v == 2) ? 2'b11 : 2'(v), 8'($urandom), 8'($urandom), 2'($urandom),
          1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
